ysyx_22040895_lsu: RTL and testbench
====================================

Name: ysyx_22040895_lsu

Overview:
- Load/store unit that consumes the memory-control bundle produced by the instruction decoder (sl, munit, mwe, plus load signedness).
- Executes one data-memory access per request over a valid/ready memory port with 8-byte-aligned beats.
- Generates the write byte mask and lane-shifted store data, then extracts and sign/zero-extends load data.
- Sits between EX and WB and stalls the pipeline via busy until the access completes.

Parameters:
- XLEN, 64, data width in bits; address width equals XLEN.
- MASK_W, XLEN/8, byte-strobe width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-low reset.
- start_i_lsu  input  1  one-cycle request strobe from EX; sampled only in IDLE.
- sl_i_lsu  input  2  01 store, 10 load, 00/11 none.
- munit_i_lsu  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
- unsigned_i_lsu  input  1  loads only; 1 = zero-extend (func3[2]).
- mwe_i_lsu  input  1  store write enable; must equal (sl==01).
- addr_i_lsu  input  XLEN  effective address (ALU result).
- wdata_i_lsu  input  XLEN  rs2 value; low bytes are used.
- busy_o_lsu  output  1  high from start acceptance until the done cycle, inclusive of neither endpoint state IDLE.
- done_o_lsu  output  1  one-cycle completion pulse.
- rdata_o_lsu  output  XLEN  extended load result; valid while done is high, then held.
- misalign_o_lsu  output  1  pulses with done when the access was misaligned.
- mem_req_valid_o_lsu  output  1  memory request valid.
- mem_req_ready_i_lsu  input  1  memory accepts the request.
- mem_we_o_lsu  output  1  1 = write.
- mem_addr_o_lsu  output  XLEN  addr with bits [2:0] cleared.
- mem_wmask_o_lsu  output  MASK_W  byte strobes.
- mem_wdata_o_lsu  output  XLEN  lane-shifted store data.
- mem_rsp_valid_i_lsu  input  1  read data valid.
- mem_rdata_i_lsu  input  XLEN  aligned 8-byte read beat.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0; rdata_o_lsu is 0.
  - An in-flight access is abandoned and a late mem_rsp_valid is ignored.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - start with sl==00 or 11 produces done on the next cycle, with rdata unchanged and no memory request.
  - start with sl in {01, 10} latches addr, size, signedness, wdata and direction.
  - Misalignment check: misaligned when addr is not a multiple of 2^munit.
  - Misaligned access goes to DONE with misalign=1 and no memory request.
  - Aligned access goes to REQ.
- REQ:
  - mem_req_valid=1; request fields stay stable until ready.
  - On ready, a store goes to DONE and a load goes to RESP.
  - valid must not drop before ready.
- RESP: wait for mem_rsp_valid; on that cycle capture the extracted data and go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy_o_lsu = (state != IDLE).
- start asserted while busy is ignored; upstream holds the instruction while busy.
- Byte offset off = addr[2:0].
- Store mask: base mask {1, 3, F, FF} for sizes {b, h, w, d}, shifted left by off.
- Store data: wdata shifted left by 8*off.
- Load extraction: mem_rdata shifted right by 8*off, truncated to the access size, then sign- or zero-extended.
  - Double loads ignore unsigned_i_lsu.
- Minimum latency from start to done: store 2 cycles (ready already high), load 3 cycles (ready and rsp each in one cycle).
- Back-to-back: a start in the cycle after done is accepted.
- Simultaneous ready and rsp_valid in REQ: rsp is not sampled in REQ; memory must present rsp no earlier than the cycle after ready.

Decomposition:
- Shared define file holds:
  - sl encodings (SL_NONE=00, SL_STORE=01, SL_LOAD=10).
  - munit encodings (MU_B/H/W/D).
  - FSM state encoding.
  - XLEN.
- One sub-module is natural: ysyx_22040895_lsu_align. It is combinational and maps (off, size, unsigned, wdata, rdata) to (wmask, wdata_shifted, rdata_ext).
- The FSM stays in the top module.

Test Plan:
- Store byte: addr=0x80000005, munit=00, wdata=0xAB, ready high -> mem_addr=0x80000000, wmask=0x20, wdata=0x0000AB0000000000, done 2 cycles after start.
- Signed load half: addr=0x80000002, munit=01, unsigned=0, rdata=0x00000000_8001_0000 -> rdata_o=0xFFFFFFFFFFFF8001.
- Unsigned load word: addr=0x80000004, munit=10, unsigned=1, rdata=0xF0000000_00000000 -> rdata_o=0x00000000F0000000.
- Misaligned: sd at addr=0x80000004 -> no mem_req_valid, done and misalign pulse 1 cycle after start.
- Backpressure: ready low 3 cycles, rsp 2 cycles later -> req fields stable throughout, busy high, done at cycle 7.
- Reset in RESP: rst=0 for one cycle, then rsp_valid arrives -> no done, busy=0, rdata_o=0, next start works.

Source files
------------

// File: rtl/ysyx_22040895_lsu_pkg.sv
// Shared definitions for the load/store unit.
//  - sl encodings      : SL_NONE / SL_STORE / SL_LOAD (11 also means "none")
//  - munit encodings   : MU_B / MU_H / MU_W / MU_D (access size 1/2/4/8 bytes)
//  - lsu_state_e       : FSM state encoding (IDLE, REQ, RESP, DONE)
//  - XLEN / MASK_W     : default datapath and byte-strobe widths
//  - is_misaligned()   : natural-alignment check for an access
package ysyx_22040895_lsu_pkg;

  localparam int XLEN   = 64;
  localparam int MASK_W = XLEN / 8;

  localparam logic [1:0] SL_NONE  = 2'b00;
  localparam logic [1:0] SL_STORE = 2'b01;
  localparam logic [1:0] SL_LOAD  = 2'b10;

  localparam logic [1:0] MU_B = 2'b00;
  localparam logic [1:0] MU_H = 2'b01;
  localparam logic [1:0] MU_W = 2'b10;
  localparam logic [1:0] MU_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  // An access is misaligned when the address is not a multiple of its size.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] munit);
    logic mis;
    unique case (munit)
      MU_B:    mis = 1'b0;
      MU_H:    mis = off[0];
      MU_W:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_22040895_lsu_align.sv
// Combinational lane alignment for the LSU.
// Ports:
//  off_i      : byte offset of the access inside the 8-byte beat
//  size_i     : access size (munit encoding)
//  unsigned_i : 1 = zero-extend loads (ignored for doubles)
//  wdata_i    : store data, value in the low bytes
//  rdata_i    : aligned 8-byte read beat from memory
//  wmask_o    : byte strobes for the store
//  wdata_o    : store data moved onto its byte lanes
//  rdata_o    : load value extracted from its lanes and extended to XLEN
module ysyx_22040895_lsu_align
  import ysyx_22040895_lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int MASK_W = XLEN / 8
) (
  input  logic [2:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [MASK_W-1:0] wmask_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   rdata_o
);

  logic [5:0]        bit_sh;
  logic [MASK_W-1:0] base_mask;
  logic [XLEN-1:0]   rd_sh;

  assign bit_sh = {off_i, 3'b000};

  always_comb begin
    base_mask = '0;
    unique case (size_i)
      MU_B:    base_mask = MASK_W'(8'h01);
      MU_H:    base_mask = MASK_W'(8'h03);
      MU_W:    base_mask = MASK_W'(8'h0F);
      default: base_mask = MASK_W'(8'hFF);
    endcase
  end

  assign wmask_o = base_mask << off_i;
  assign wdata_o = wdata_i << bit_sh;
  assign rd_sh   = rdata_i >> bit_sh;

  always_comb begin
    rdata_o = '0;
    unique case (size_i)
      MU_B: rdata_o = unsigned_i ? {{(XLEN-8){1'b0}}, rd_sh[7:0]}
                                 : {{(XLEN-8){rd_sh[7]}}, rd_sh[7:0]};
      MU_H: rdata_o = unsigned_i ? {{(XLEN-16){1'b0}}, rd_sh[15:0]}
                                 : {{(XLEN-16){rd_sh[15]}}, rd_sh[15:0]};
      MU_W: rdata_o = unsigned_i ? {{(XLEN-32){1'b0}}, rd_sh[31:0]}
                                 : {{(XLEN-32){rd_sh[31]}}, rd_sh[31:0]};
      default: rdata_o = rd_sh;
    endcase
  end

endmodule

// File: rtl/ysyx_22040895_lsu.sv
// Load/store unit between EX and WB: one data-memory access per request.
// Ports:
//  clk, rst (sync, active low)
//  start/sl/munit/unsigned/mwe/addr/wdata *_i_lsu : request from EX (sampled in IDLE)
//  busy/done/rdata/misalign *_o_lsu               : status and load result to the pipeline
//  mem_req_* / mem_rsp_*                          : valid/ready memory port, 8-byte beats
//  dbg_state_o_lsu                                : current FSM state
// Handshake: a request is transferred on a cycle where mem_req_valid and
// mem_req_ready are both high; valid and every request field stay stable
// until that cycle. Read data is taken only in RESP, i.e. no earlier than the
// cycle after the request was accepted.
module ysyx_22040895_lsu
  import ysyx_22040895_lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int MASK_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i_lsu,
  input  logic [1:0]        sl_i_lsu,
  input  logic [1:0]        munit_i_lsu,
  input  logic              unsigned_i_lsu,
  input  logic              mwe_i_lsu,
  input  logic [XLEN-1:0]   addr_i_lsu,
  input  logic [XLEN-1:0]   wdata_i_lsu,
  output logic              busy_o_lsu,
  output logic              done_o_lsu,
  output logic [XLEN-1:0]   rdata_o_lsu,
  output logic              misalign_o_lsu,
  output logic              mem_req_valid_o_lsu,
  input  logic              mem_req_ready_i_lsu,
  output logic              mem_we_o_lsu,
  output logic [XLEN-1:0]   mem_addr_o_lsu,
  output logic [MASK_W-1:0] mem_wmask_o_lsu,
  output logic [XLEN-1:0]   mem_wdata_o_lsu,
  input  logic              mem_rsp_valid_i_lsu,
  input  logic [XLEN-1:0]   mem_rdata_i_lsu,
  output lsu_state_e        dbg_state_o_lsu
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic [MASK_W-1:0] wmask_al;
  logic [XLEN-1:0]   wdata_al;
  logic [XLEN-1:0]   rdata_ext;

  ysyx_22040895_lsu_align #(.XLEN(XLEN), .MASK_W(MASK_W)) u_align (
    .off_i      (addr_q[2:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rdata_i    (mem_rdata_i_lsu),
    .wmask_o    (wmask_al),
    .wdata_o    (wdata_al),
    .rdata_o    (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i_lsu) begin
          mis_d = 1'b0;
          if (sl_i_lsu == SL_STORE || sl_i_lsu == SL_LOAD) begin
            addr_d  = addr_i_lsu;
            size_d  = munit_i_lsu;
            uns_d   = unsigned_i_lsu;
            wdata_d = wdata_i_lsu;
            we_d    = mwe_i_lsu;
            if (is_misaligned(addr_i_lsu[2:0], munit_i_lsu)) begin
              mis_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_REQ;
            end
          end else begin
            // No memory operation: complete immediately, rdata untouched.
            state_d = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready_i_lsu) begin
          state_d = we_q ? ST_DONE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_rsp_valid_i_lsu) begin
          rdata_d = rdata_ext;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o_lsu          = (state_q != ST_IDLE);
  assign done_o_lsu          = (state_q == ST_DONE);
  assign misalign_o_lsu      = (state_q == ST_DONE) && mis_q;
  assign rdata_o_lsu         = rdata_q;
  assign mem_req_valid_o_lsu = (state_q == ST_REQ);
  assign mem_we_o_lsu        = we_q;
  assign mem_addr_o_lsu      = {addr_q[XLEN-1:3], 3'b000};
  assign mem_wmask_o_lsu     = (state_q == ST_REQ && we_q) ? wmask_al : '0;
  assign mem_wdata_o_lsu     = wdata_al;
  assign dbg_state_o_lsu     = state_q;

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
module tb_ysyx_22040895_lsu;
  import ysyx_22040895_lsu_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  sl, munit;
  logic        uns, mwe;
  logic [63:0] addr, wdata;
  logic        busy, done, misalign;
  logic [63:0] rdata;
  logic        req_valid, req_ready, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        rsp_valid;
  lsu_state_e  dbg_state;

  always #5 clk = ~clk;

  ysyx_22040895_lsu dut (
    .clk                 (clk),
    .rst                 (rst),
    .start_i_lsu         (start),
    .sl_i_lsu            (sl),
    .munit_i_lsu         (munit),
    .unsigned_i_lsu      (uns),
    .mwe_i_lsu           (mwe),
    .addr_i_lsu          (addr),
    .wdata_i_lsu         (wdata),
    .busy_o_lsu          (busy),
    .done_o_lsu          (done),
    .rdata_o_lsu         (rdata),
    .misalign_o_lsu      (misalign),
    .mem_req_valid_o_lsu (req_valid),
    .mem_req_ready_i_lsu (req_ready),
    .mem_we_o_lsu        (mem_we),
    .mem_addr_o_lsu      (mem_addr),
    .mem_wmask_o_lsu     (mem_wmask),
    .mem_wdata_o_lsu     (mem_wdata),
    .mem_rsp_valid_i_lsu (rsp_valid),
    .mem_rdata_i_lsu     (mem_rdata),
    .dbg_state_o_lsu     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] last_rdata;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  sl;
    logic [1:0]  munit;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [7:0]  wmask;
    logic [63:0] wsh;
    logic [63:0] rext;
    logic        mis;
    int          rd_dly;
    int          rsp_dly;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] s, input logic [1:0] m, input logic u,
                              input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                              input logic [7:0] wm, input logic [63:0] ws, input logic [63:0] re,
                              input logic mi, input int rdd, input int rspd);
    vec_t v;
    v.sl = s; v.munit = m; v.uns = u; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.wmask = wm; v.wsh = ws; v.rext = re; v.mis = mi; v.rd_dly = rdd; v.rsp_dly = rspd;
    return v;
  endfunction

  localparam int NV = 17;
  vec_t vecs[NV];

  // ---------------- driver: one transaction with a reactive memory ----------------
  task automatic run_vec(input vec_t v, input int idx);
    logic is_acc, is_ld, want_req;
    int exp_lat, cyc, req_wait, rsp_wait;
    bit accepted, finished;
    logic [63:0] exp_r, got_exp;
    is_acc   = (v.sl == SL_STORE) || (v.sl == SL_LOAD);
    is_ld    = (v.sl == SL_LOAD);
    want_req = is_acc && !v.mis;
    if (!want_req)   exp_lat = 1;
    else if (!is_ld) exp_lat = 2 + v.rd_dly;
    else             exp_lat = 3 + v.rd_dly + v.rsp_dly;
    exp_r = (want_req && is_ld) ? v.rext : last_rdata;
    last_rdata = exp_r;

    @(negedge clk);
    start = 1'b1; sl = v.sl; munit = v.munit; uns = v.uns;
    mwe = (v.sl == SL_STORE); addr = v.addr; wdata = v.wdata;
    req_ready = 1'b0; rsp_valid = 1'b0;
    exp_q.push_back(exp_r);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; req_wait = 0; rsp_wait = 0; accepted = 0; finished = 0;
    while (!finished && cyc <= 40) begin
      if (done) begin
        chk($sformatf("v%0d latency", idx), 64'(cyc), 64'(exp_lat));
        chk($sformatf("v%0d misalign", idx), 64'(misalign), 64'(v.mis));
        got_exp = exp_q.pop_front();
        chk($sformatf("v%0d rdata", idx), rdata, got_exp);
        req_ready = 1'b0; rsp_valid = 1'b0;
        finished = 1;
      end else begin
        chk($sformatf("v%0d busy", idx), 64'(busy), 64'd1);
        if (req_valid) begin
          chk($sformatf("v%0d req_expected", idx), 64'd1, 64'(want_req));
          chk($sformatf("v%0d mem_addr", idx), mem_addr, v.addr & ~64'h7);
          chk($sformatf("v%0d mem_we", idx), 64'(mem_we), 64'(!is_ld));
          if (!is_ld) begin
            chk($sformatf("v%0d wmask", idx), 64'(mem_wmask), 64'(v.wmask));
            chk($sformatf("v%0d wdata", idx), mem_wdata, v.wsh);
          end
          req_ready = (req_wait >= v.rd_dly);
          accepted = req_ready;
          rsp_valid = 1'b0;
          req_wait++;
        end else begin
          req_ready = 1'b0;
          if (accepted && is_ld) begin
            rsp_valid = (rsp_wait >= v.rsp_dly);
            mem_rdata = rsp_valid ? v.rdata : 64'hDEAD_BEEF_0BAD_F00D;
            rsp_wait++;
          end
        end
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!finished) begin
      chk($sformatf("v%0d done_timeout", idx), 64'd0, 64'd1);
      void'(exp_q.pop_front());
      req_ready = 1'b0; rsp_valid = 1'b0;
    end
  endtask

  // Load aborted by reset while waiting in RESP; the late response is ignored.
  task automatic reset_in_resp();
    @(negedge clk);
    start = 1'b1; sl = SL_LOAD; munit = MU_W; uns = 1'b0; mwe = 1'b0;
    addr = 64'h8000_0000; wdata = '0; req_ready = 1'b0; rsp_valid = 1'b0;
    @(negedge clk);               // REQ
    start = 1'b0;
    chk("rr req_valid", 64'(req_valid), 64'd1);
    req_ready = 1'b1;
    @(negedge clk);               // RESP
    req_ready = 1'b0;
    chk("rr in_resp busy", 64'(busy), 64'd1);
    rst = 1'b0;
    @(negedge clk);               // IDLE after reset
    rst = 1'b1;
    rsp_valid = 1'b1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    chk("rr busy_after_rst", 64'(busy), 64'd0);
    chk("rr done_after_rst", 64'(done), 64'd0);
    @(negedge clk);
    rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rr late_rsp done", 64'(done), 64'd0);
      chk("rr late_rsp busy", 64'(busy), 64'd0);
      chk("rr late_rsp rdata", rdata, 64'd0);
      @(negedge clk);
    end
    last_rdata = '0;
  endtask

  // ---------------- main ----------------
  initial begin
    vecs[0]  = mk(SL_STORE, MU_B, 0, 64'h8000_0005, 64'h0000_0000_0000_00AB, 0,
                  8'h20, 64'h0000_AB00_0000_0000, 0, 0, 0, 0);
    vecs[1]  = mk(SL_LOAD, MU_H, 0, 64'h8000_0002, 0, 64'h0000_0000_8001_0000,
                  0, 0, 64'hFFFF_FFFF_FFFF_8001, 0, 0, 0);
    vecs[2]  = mk(SL_LOAD, MU_W, 1, 64'h8000_0004, 0, 64'hF000_0000_0000_0000,
                  0, 0, 64'h0000_0000_F000_0000, 0, 0, 0);
    vecs[3]  = mk(SL_STORE, MU_D, 0, 64'h8000_0004, 64'h1111_2222_3333_4444, 0,
                  0, 0, 0, 1, 0, 0);
    vecs[4]  = mk(SL_STORE, MU_D, 0, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 0,
                  8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0);
    vecs[5]  = mk(SL_STORE, MU_W, 0, 64'h8000_000C, 64'hFFFF_FFFF_1122_3344, 0,
                  8'hF0, 64'h1122_3344_0000_0000, 0, 0, 0, 0);
    vecs[6]  = mk(SL_STORE, MU_H, 0, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 0,
                  8'hC0, 64'hBEEF_0000_0000_0000, 0, 0, 0, 0);
    vecs[7]  = mk(SL_LOAD, MU_B, 0, 64'h8000_0007, 0, 64'h8000_0000_0000_0000,
                  0, 0, 64'hFFFF_FFFF_FFFF_FF80, 0, 0, 0);
    vecs[8]  = mk(SL_LOAD, MU_B, 1, 64'h8000_0003, 0, 64'h0000_0000_FE00_0000,
                  0, 0, 64'h0000_0000_0000_00FE, 0, 0, 0);
    vecs[9]  = mk(SL_LOAD, MU_D, 1, 64'h8000_0010, 0, 64'h8877_6655_4433_2211,
                  0, 0, 64'h8877_6655_4433_2211, 0, 0, 0);
    vecs[10] = mk(SL_LOAD, MU_W, 0, 64'h8000_0000, 0, 64'h0000_0000_8765_4321,
                  0, 0, 64'hFFFF_FFFF_8765_4321, 0, 0, 0);
    vecs[11] = mk(SL_NONE, MU_D, 0, 64'h8000_0020, 64'hFFFF, 0, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(SL_LOAD, MU_H, 0, 64'h8000_0001, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[13] = mk(2'b11, MU_W, 0, 64'h8000_0030, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(SL_LOAD, MU_H, 1, 64'h8000_000E, 0, 64'hFFFE_0000_0000_0000,
                  0, 0, 64'h0000_0000_0000_FFFE, 0, 0, 0);
    vecs[15] = mk(SL_LOAD, MU_W, 0, 64'h8000_0004, 0, 64'h7FFF_FFFF_0000_0000,
                  0, 0, 64'h0000_0000_7FFF_FFFF, 0, 3, 1);
    vecs[16] = mk(SL_STORE, MU_B, 0, 64'h8000_0000, 64'h0000_0000_0000_0055, 0,
                  8'h01, 64'h0000_0000_0000_0055, 0, 0, 2, 0);

    rst = 1'b0; start = 1'b0; sl = '0; munit = '0; uns = 1'b0; mwe = 1'b0;
    addr = '0; wdata = '0; req_ready = 1'b0; rsp_valid = 1'b0; mem_rdata = '0;
    last_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset rdata", rdata, 64'd0);
    chk("reset misalign", 64'(misalign), 64'd0);
    chk("reset req_valid", 64'(req_valid), 64'd0);
    chk("reset mem_we", 64'(mem_we), 64'd0);
    chk("reset wmask", 64'(mem_wmask), 64'd0);
    rst = 1'b1;

    // Consecutive vectors start in the cycle right after the previous done.
    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    reset_in_resp();
    run_vec(vecs[1], 100);
    run_vec(vecs[0], 101);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
